// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register-file addressing, write-back bypass,
// immediate/control generation and the ID/EX pipeline register with valid/ready handshake.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     inInstr,
    input  logic [XLEN-1:0] inPc,
    input  logic            flush,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic            wbEn,
    input  logic [4:0]      wbRd,
    input  logic [XLEN-1:0] wbData,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outPc,
    output logic [XLEN-1:0] outRs1Val,
    output logic [XLEN-1:0] outRs2Val,
    output logic [XLEN-1:0] outImm,
    output logic [4:0]      outRd,
    output logic [2:0]      outFunct3,
    output logic [3:0]      outAluOp,
    output logic            outAluSrcImm,
    output logic            outAluSrcPc,
    output logic            outRegWr,
    output logic            outMemRd,
    output logic            outMemWr,
    output logic            outBranch,
    output logic            outJump,
    output logic            outIllegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic            w_load;
    logic            w_f7_ok;

    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu_op;
    logic            w_src_imm, w_src_pc, w_reg_wr, w_mem_rd, w_mem_wr;
    logic            w_branch, w_jump, w_illegal;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [3:0]      r_alu_op;
    logic            r_src_imm, r_src_pc, r_reg_wr, r_mem_rd, r_mem_wr;
    logic            r_branch, r_jump, r_illegal;

    assign w_opcode = inInstr[6:0];
    assign w_rd     = inInstr[11:7];
    assign w_funct3 = inInstr[14:12];
    assign w_funct7 = inInstr[31:25];
    assign rs1      = inInstr[19:15];
    assign rs2      = inInstr[24:20];

    assign w_imm_i = {{20{inInstr[31]}}, inInstr[31:20]};
    assign w_imm_s = {{20{inInstr[31]}}, inInstr[31:25], inInstr[11:7]};
    assign w_imm_b = {{19{inInstr[31]}}, inInstr[31], inInstr[7], inInstr[30:25], inInstr[11:8], 1'b0};
    assign w_imm_u = {inInstr[31:12], 12'b0};
    assign w_imm_j = {{11{inInstr[31]}}, inInstr[31], inInstr[19:12], inInstr[20], inInstr[30:21], 1'b0};

    // The regFile write lands on the same edge we latch, so forward it; x0 never forwards
    assign w_rs1_val = (wbEn && (wbRd != 5'd0) && (wbRd == rs1)) ? wbData : r1;
    assign w_rs2_val = (wbEn && (wbRd != 5'd0) && (wbRd == rs2)) ? wbData : r2;

    assign inReady = !r_valid || outReady;
    assign w_load  = inValid && inReady && !flush;

    assign w_f7_ok = (w_funct7 == 7'b0000000) ||
                     ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

    always_comb begin
        w_imm     = '0;
        w_alu_op  = ALU_ADD;
        w_src_imm = 1'b0;
        w_src_pc  = 1'b0;
        w_reg_wr  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_alu_op  = alu_from_f3(w_funct3, w_funct7[5]);
                w_reg_wr  = 1'b1;
                w_illegal = !w_f7_ok;
            end
            OPC_OP_IMM: begin
                w_alu_op  = alu_from_f3(w_funct3, (w_funct3 == 3'b101) && inInstr[30]);
                w_imm     = w_imm_i;
                w_src_imm = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_LOAD: begin
                w_imm     = w_imm_i;
                w_src_imm = 1'b1;
                w_mem_rd  = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_STORE: begin
                w_imm     = w_imm_s;
                w_src_imm = 1'b1;
                w_mem_wr  = 1'b1;
            end
            OPC_BRANCH: begin
                w_alu_op  = ALU_SUB;
                w_imm     = w_imm_b;
                w_branch  = 1'b1;
            end
            OPC_JAL: begin
                w_imm     = w_imm_j;
                w_src_imm = 1'b1;
                w_src_pc  = 1'b1;
                w_jump    = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_JALR: begin
                w_imm     = w_imm_i;
                w_src_imm = 1'b1;
                w_jump    = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_LUI: begin
                w_alu_op  = ALU_PASSB;
                w_imm     = w_imm_u;
                w_src_imm = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm     = w_imm_u;
                w_src_imm = 1'b1;
                w_src_pc  = 1'b1;
                w_reg_wr  = 1'b1;
            end
            OPC_FENCE: ;
            default:   w_illegal = 1'b1;
        endcase
        // Illegal instructions still flow down the pipe but must have no side effects
        if (w_illegal) begin
            w_reg_wr = 1'b0;
            w_mem_rd = 1'b0;
            w_mem_wr = 1'b0;
            w_branch = 1'b0;
            w_jump   = 1'b0;
        end
        if (w_rd == 5'd0) w_reg_wr = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_alu_op  <= '0;
            r_src_imm <= 1'b0;
            r_src_pc  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (flush)          r_valid <= 1'b0;
            else if (w_load)    r_valid <= 1'b1;
            else if (outReady)  r_valid <= 1'b0;

            if (w_load) begin
                r_pc      <= inPc;
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_rd      <= w_rd;
                r_funct3  <= w_funct3;
                r_alu_op  <= w_alu_op;
                r_src_imm <= w_src_imm;
                r_src_pc  <= w_src_pc;
                r_reg_wr  <= w_reg_wr;
                r_mem_rd  <= w_mem_rd;
                r_mem_wr  <= w_mem_wr;
                r_branch  <= w_branch;
                r_jump    <= w_jump;
                r_illegal <= w_illegal;
            end
        end
    end

    assign outValid     = r_valid;
    assign outPc        = r_pc;
    assign outRs1Val    = r_rs1_val;
    assign outRs2Val    = r_rs2_val;
    assign outImm       = r_imm;
    assign outRd        = r_rd;
    assign outFunct3    = r_funct3;
    assign outAluOp     = r_alu_op;
    assign outAluSrcImm = r_src_imm;
    assign outAluSrcPc  = r_src_pc;
    assign outRegWr     = r_reg_wr;
    assign outMemRd     = r_mem_rd;
    assign outMemWr     = r_mem_wr;
    assign outBranch    = r_branch;
    assign outJump      = r_jump;
    assign outIllegal   = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus reset, stall/flush and
// back-to-back handshake sequences.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady;
    logic [31:0] inInstr, inPc;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic [31:0] r1, r2;
    logic        wbEn;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        outValid, outReady;
    logic [31:0] outPc, outRs1Val, outRs2Val, outImm;
    logic [4:0]  outRd;
    logic [2:0]  outFunct3;
    logic [3:0]  outAluOp;
    logic        outAluSrcImm, outAluSrcPc, outRegWr, outMemRd, outMemWr;
    logic        outBranch, outJump, outIllegal;

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inInstr(inInstr), .inPc(inPc),
        .flush(flush), .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2),
        .wbEn(wbEn), .wbRd(wbRd), .wbData(wbData),
        .outValid(outValid), .outReady(outReady),
        .outPc(outPc), .outRs1Val(outRs1Val), .outRs2Val(outRs2Val), .outImm(outImm),
        .outRd(outRd), .outFunct3(outFunct3), .outAluOp(outAluOp),
        .outAluSrcImm(outAluSrcImm), .outAluSrcPc(outAluSrcPc), .outRegWr(outRegWr),
        .outMemRd(outMemRd), .outMemWr(outMemWr), .outBranch(outBranch),
        .outJump(outJump), .outIllegal(outIllegal)
    );

    always #5 clk = ~clk;

    // flags = {regWr, memRd, memWr, branch, jump, illegal, srcPc}
    // don't-care markers: rd = 6'h3F, alu = 4'hF, src_imm = 2
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        chk_imm;
        logic [31:0] imm;
        logic [5:0]  rd;
        logic [3:0]  alu;
        logic [1:0]  src_imm;
        logic [6:0]  flags;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
    } vec_t;

    vec_t vecs[$];
    int n_pass = 0;
    int n_total = 0;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] v1, input logic [31:0] v2,
                                input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic ci, input logic [31:0] imm, input logic [5:0] rd,
                                input logic [3:0] alu, input logic [1:0] si, input logic [6:0] fl,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.instr = instr; v.r1 = v1; v.r2 = v2;
        v.wb_en = we; v.wb_rd = wr; v.wb_data = wd;
        v.chk_imm = ci; v.imm = imm; v.rd = rd; v.alu = alu; v.src_imm = si;
        v.flags = fl; v.rs1v = e1; v.rs2v = e2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [6:0] flags_now();
        return {outRegWr, outMemRd, outMemWr, outBranch, outJump, outIllegal, outAluSrcPc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        inInstr = instr;
        inPc    = pc;
        inValid = 1'b1;
    endtask

    initial begin
        rst = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; flush = 1'b0;
        r1 = '0; r2 = '0; wbEn = 1'b0; wbRd = '0; wbData = '0; outReady = 1'b1;

        //            instr         r1            r2            we wr  wdata         ci imm           rd     alu   si flags       rs1v          rs2v
        vecs.push_back(mk(32'hFFD08293, 32'h10,       32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFD, 6'd5,  4'd0, 1, 7'b1000000, 32'h10,       32'h0));
        vecs.push_back(mk(32'h0021A423, 32'h100,      32'hABCD,     0, 0, 32'h0,        1, 32'h8,        6'h3F, 4'd0, 2, 7'b0010000, 32'h100,      32'hABCD));
        vecs.push_back(mk(32'hFE208EE3, 32'h1,        32'h2,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 6'h3F, 4'd1, 2, 7'b0001000, 32'h1,        32'h2));
        vecs.push_back(mk(32'h002081B3, 32'h5,        32'h7,        0, 0, 32'h0,        0, 32'h0,        6'd3,  4'd0, 0, 7'b1000000, 32'h5,        32'h7));
        vecs.push_back(mk(32'h402081B3, 32'h9,        32'h3,        0, 0, 32'h0,        0, 32'h0,        6'd3,  4'd1, 0, 7'b1000000, 32'h9,        32'h3));
        vecs.push_back(mk(32'h4062D233, 32'h80000000, 32'h4,        0, 0, 32'h0,        0, 32'h0,        6'd4,  4'd7, 0, 7'b1000000, 32'h80000000, 32'h4));
        vecs.push_back(mk(32'h022081B3, 32'h6,        32'h6,        0, 0, 32'h0,        0, 32'h0,        6'h3F, 4'hF, 2, 7'b0000010, 32'h6,        32'h6));
        vecs.push_back(mk(32'h4032D293, 32'hF0,       32'h0,        0, 0, 32'h0,        1, 32'h403,      6'd5,  4'd7, 1, 7'b1000000, 32'hF0,       32'h0));
        vecs.push_back(mk(32'h123453B7, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h12345000, 6'd7,  4'd10,2, 7'b1000000, 32'h0,        32'h0));
        vecs.push_back(mk(32'hFFFFF097, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'hFFFFF000, 6'd1,  4'd0, 2, 7'b1000001, 32'h0,        32'h0));
        vecs.push_back(mk(32'h008000EF, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h8,        6'd1,  4'hF, 2, 7'b1000101, 32'h0,        32'h0));
        vecs.push_back(mk(32'h00008067, 32'h400,      32'h0,        0, 0, 32'h0,        1, 32'h0,        6'd0,  4'hF, 2, 7'b0000100, 32'h400,      32'h0));
        vecs.push_back(mk(32'hFFC12303, 32'h2000,     32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 6'd6,  4'd0, 2, 7'b1100000, 32'h2000,     32'h0));
        vecs.push_back(mk(32'h0FF0000F, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        6'h3F, 4'hF, 2, 7'b0000000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h0000007F, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        6'h3F, 4'hF, 2, 7'b0000010, 32'h0,        32'h0));
        vecs.push_back(mk(32'h00100013, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h1,        6'd0,  4'd0, 1, 7'b0000000, 32'h0,        32'h0));
        // bypass cases
        vecs.push_back(mk(32'h002081B3, 32'h0,        32'h22,       1, 1, 32'hFAFAFA01, 0, 32'h0,        6'd3,  4'd0, 0, 7'b1000000, 32'hFAFAFA01, 32'h22));
        vecs.push_back(mk(32'h002081B3, 32'h33,       32'h22,       1, 0, 32'hFAFAFA01, 0, 32'h0,        6'd3,  4'd0, 0, 7'b1000000, 32'h33,       32'h22));
        vecs.push_back(mk(32'h002081B3, 32'h44,       32'h0,        1, 2, 32'h12345678, 0, 32'h0,        6'd3,  4'd0, 0, 7'b1000000, 32'h44,       32'h12345678));
        vecs.push_back(mk(32'h00100293, 32'h55,       32'h0,        1, 0, 32'h0000DEAD, 1, 32'h1,        6'd5,  4'd0, 1, 7'b1000000, 32'h55,       32'h0));
        vecs.push_back(mk(32'h002081B3, 32'h66,       32'h77,       0, 1, 32'hFFFF0000, 0, 32'h0,        6'd3,  4'd0, 0, 7'b1000000, 32'h66,       32'h77));

        // reset state
        tick(); tick();
        chk("rst_outValid", {31'b0, outValid}, 32'h0);
        chk("rst_inReady",  {31'b0, inReady},  32'h1);
        chk("rst_outPc",    outPc, 32'h0);
        chk("rst_outImm",   outImm, 32'h0);
        chk("rst_flags",    {25'b0, flags_now()}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // decode table
        for (int i = 0; i < vecs.size(); i++) begin
            present(vecs[i].instr, 32'h1000 + 32'(i) * 4);
            r1 = vecs[i].r1; r2 = vecs[i].r2;
            wbEn = vecs[i].wb_en; wbRd = vecs[i].wb_rd; wbData = vecs[i].wb_data;
            #1;
            chk($sformatf("v%0d_rs1addr", i), {27'b0, rs1}, {27'b0, vecs[i].instr[19:15]});
            chk($sformatf("v%0d_rs2addr", i), {27'b0, rs2}, {27'b0, vecs[i].instr[24:20]});
            tick();
            inValid = 1'b0; wbEn = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'b0, outValid}, 32'h1);
            chk($sformatf("v%0d_pc", i), outPc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d_funct3", i), {29'b0, outFunct3}, {29'b0, vecs[i].instr[14:12]});
            chk($sformatf("v%0d_rs1val", i), outRs1Val, vecs[i].rs1v);
            chk($sformatf("v%0d_rs2val", i), outRs2Val, vecs[i].rs2v);
            chk($sformatf("v%0d_flags", i), {25'b0, flags_now()}, {25'b0, vecs[i].flags});
            if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), outImm, vecs[i].imm);
            if (vecs[i].rd != 6'h3F) chk($sformatf("v%0d_rd", i), {27'b0, outRd}, {26'b0, vecs[i].rd});
            if (vecs[i].alu != 4'hF) chk($sformatf("v%0d_alu", i), {28'b0, outAluOp}, {28'b0, vecs[i].alu});
            if (vecs[i].src_imm != 2'd2) chk($sformatf("v%0d_srcimm", i), {31'b0, outAluSrcImm}, {31'b0, vecs[i].src_imm[0]});
        end
        tick();
        chk("drain_valid", {31'b0, outValid}, 32'h0);

        // stall three cycles then flush
        r1 = 32'hA1; r2 = 32'hB2;
        present(32'h002081B3, 32'h2000);
        tick();
        outReady = 1'b0;
        present(32'h00100293, 32'h2004);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_inReady", c), {31'b0, inReady}, 32'h0);
            tick();
            chk($sformatf("stall%0d_valid", c), {31'b0, outValid}, 32'h1);
            chk($sformatf("stall%0d_pc", c), outPc, 32'h2000);
            chk($sformatf("stall%0d_rd", c), {27'b0, outRd}, 32'd3);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, outValid}, 32'h0);
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
        chk("after_flush_valid", {31'b0, outValid}, 32'h1);
        chk("after_flush_pc", outPc, 32'h2004);
        chk("after_flush_imm", outImm, 32'h1);
        tick();
        chk("no_dup_valid", {31'b0, outValid}, 32'h0);

        // back-to-back accept with drain, no bubble
        present(32'hFFD08293, 32'h3000);
        tick();
        present(32'h123453B7, 32'h3004);
        tick();
        inValid = 1'b0;
        chk("b2b_valid", {31'b0, outValid}, 32'h1);
        chk("b2b_pc", outPc, 32'h3004);
        chk("b2b_alu", {28'b0, outAluOp}, 32'd10);

        // asynchronous reset while a bundle is stalled
        outReady = 1'b0;
        r1 = 32'hC3;
        present(32'h002081B3, 32'h4000);
        tick();
        inValid = 1'b0;
        chk("pre_rst_valid", {31'b0, outValid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid",   {31'b0, outValid}, 32'h0);
        chk("midrst_inReady", {31'b0, inReady},  32'h1);
        chk("midrst_pc",      outPc, 32'h0);
        chk("midrst_rs1val",  outRs1Val, 32'h0);
        chk("midrst_flags",   {25'b0, flags_now()}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        outReady = 1'b1;
        present(32'h0021A423, 32'h5000);
        #1;
        chk("post_rst_before_edge", {31'b0, outValid}, 32'h0);
        tick();
        inValid = 1'b0;
        chk("post_rst_valid", {31'b0, outValid}, 32'h1);
        chk("post_rst_pc", outPc, 32'h5000);
        chk("post_rst_memwr", {31'b0, outMemWr}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
